// File: rtl/config_loader.sv
// Serial config loader: shifts MEM_SIZE-bit words in LSB-first and strobes them into
// NUM_BLOCKS latch blocks in order. Define CONFIG_PARITY_EN for a per-word even-parity check.
module config_loader #(
    parameter int MEM_SIZE   = 16,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_ready,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic [NUM_BLOCKS-1:0] comb_set,
    output logic                  busy,
`ifdef CONFIG_PARITY_EN
    output logic                  done,
    output logic                  err
`else
    output logic                  done
`endif
);
    localparam int CNT_W = $clog2(MEM_SIZE + 1);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [NUM_BLOCKS-1:0] STROBE0  = NUM_BLOCKS'(1);
`ifdef CONFIG_PARITY_EN
    // The extra accept per word carries the parity bit, which never enters the word.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_SIZE);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_SIZE - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_DONE
`ifdef CONFIG_PARITY_EN
        , S_ERROR
`endif
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            config_out <= '0;
            comb_set   <= '0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CONFIG_PARITY_EN
            err        <= 1'b0;
`endif
        end else begin
            comb_set <= '0;
            if (start && (state != S_SHIFT) && (state != S_COMMIT)) begin
                state     <= S_SHIFT;
                idx       <= '0;
                cnt       <= '0;
                cfg_ready <= 1'b1;
                busy      <= 1'b1;
                done      <= 1'b0;
`ifdef CONFIG_PARITY_EN
                err       <= 1'b0;
`endif
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (cfg_valid) begin
                            if (cnt == LAST_CNT) begin
                                cnt       <= '0;
                                cfg_ready <= 1'b0;
`ifdef CONFIG_PARITY_EN
                                if (cfg_bit != ^config_out) begin
                                    state <= S_ERROR;
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state    <= S_COMMIT;
                                    comb_set <= STROBE0 << idx;
                                end
`else
                                config_out <= {cfg_bit, config_out[MEM_SIZE-1:1]};
                                state      <= S_COMMIT;
                                comb_set   <= STROBE0 << idx;
`endif
                            end else begin
                                cnt        <= cnt + CNT_W'(1);
                                config_out <= {cfg_bit, config_out[MEM_SIZE-1:1]};
                            end
                        end
                    end
                    S_COMMIT: begin
                        // comb_set self-clears here, so the strobe is exactly one cycle wide
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_SHIFT;
                            cfg_ready <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// Randomized self-checking bench for config_loader; expected commits are derived
// from the generated word list, never from the DUT.
module tb_config_loader;
    localparam int MS = 16;
    localparam int NB = 4;
`ifdef CONFIG_PARITY_EN
    localparam int BPW = MS + 1;
`else
    localparam int BPW = MS;
`endif
    localparam int PERIOD = BPW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic [MS-1:0] config_out;
    logic [NB-1:0] comb_set;
    logic          busy;
    logic          done;
`ifdef CONFIG_PARITY_EN
    logic          err;
`endif

    config_loader #(.MEM_SIZE(MS), .NUM_BLOCKS(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .config_out(config_out), .comb_set(comb_set),
        .busy(busy),
`ifdef CONFIG_PARITY_EN
        .done(done), .err(err)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] cs;
        logic [MS-1:0] w;
    } ev_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            inv_err = 0;
    ev_t           evq[$];
    logic          bitq[$];
    logic [MS-1:0] words[NB];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and watch handshake/strobe invariants away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        if (comb_set != '0) begin
            e.cyc = cyc;
            e.cs  = comb_set;
            e.w   = config_out;
            evq.push_back(e);
        end
        if (!rst) begin
            if (cfg_ready !== (busy && (comb_set == '0))) inv_err++;
            if (!$onehot0(comb_set)) inv_err++;
            if (done && busy) inv_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_config_out"}, 64'(config_out), 64'(0));
        check({tag, "_comb_set"}, 64'(comb_set), 64'(0));
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
`ifdef CONFIG_PARITY_EN
        check({tag, "_err"}, 64'(err), 64'(0));
`endif
    endtask

    task automatic push_word(input logic [MS-1:0] w, input logic par_flip);
        for (int i = 0; i < MS; i++) bitq.push_back(w[i]);
`ifdef CONFIG_PARITY_EN
        bitq.push_back((^w) ^ par_flip);
`else
        if (par_flip) bitq.push_back(1'b0);
`endif
    endtask

    task automatic fill_rand();
        logic [31:0] tmp;
        for (int i = 0; i < NB; i++) begin
            tmp = $urandom();
            words[i] = tmp[MS-1:0];
        end
    endtask

    task automatic load_words();
        for (int i = 0; i < NB; i++) push_word(words[i], 1'b0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer queued bits (every cycle, or every third cycle when gapped) until n are accepted.
    task automatic feed(input int n, input int gapped);
        int   got = 0;
        int   k = 0;
        logic acc;
        while (got < n && k < 4000) begin
            cfg_valid = (bitq.size() > 0) && (gapped == 0 || (k % 3) == 0);
            cfg_bit   = (bitq.size() > 0) ? bitq[0] : 1'b0;
            acc       = cfg_valid && cfg_ready;
            @(posedge clk); #1;
            if (acc) begin
                void'(bitq.pop_front());
                got++;
            end
            k++;
        end
        cfg_valid = 1'b0;
        check("feed_accepts", 64'(got), 64'(n));
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_reached", 64'(done), 64'(1));
    endtask

    task automatic check_seq(input string tag, input int gapped);
        logic [NB-1:0] one = NB'(1);
        check({tag, "_n_commits"}, 64'(evq.size()), 64'(NB));
        for (int i = 0; i < NB && i < evq.size(); i++) begin
            check($sformatf("%s_strobe%0d", tag, i), 64'(evq[i].cs), 64'(one << i));
            check($sformatf("%s_word%0d", tag, i), 64'(evq[i].w), 64'(words[i]));
            if (gapped == 0 && i > 0)
                check($sformatf("%s_period%0d", tag, i), 64'(evq[i].cyc - evq[i-1].cyc), 64'(PERIOD));
        end
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        check({tag, "_hold_word"}, 64'(config_out), 64'(words[NB-1]));
    endtask

    initial begin
        #3;
        check_quiet("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_quiet("idle");

        // Back-to-back stream, first word fixed.
        fill_rand();
        words[0] = 16'hA5C3;
        evq.delete();
        bitq.delete();
        load_words();
        start_pulse();
        check("a_busy", 64'(busy), 64'(1));
        check("a_ready", 64'(cfg_ready), 64'(1));
        feed(NB * BPW, 0);
        wait_done();
        check_seq("a", 0);

        // Restart from DONE, same words, gapped valid.
        evq.delete();
        start_pulse();
        check("b_done_fall", 64'(done), 64'(0));
        check("b_busy", 64'(busy), 64'(1));
        check("b_ready", 64'(cfg_ready), 64'(1));
        load_words();
        feed(NB * BPW, 1);
        wait_done();
        check_seq("b", 1);

        // start during block 2 must be ignored.
        fill_rand();
        evq.delete();
        load_words();
        start_pulse();
        feed(2 * BPW + 5, 0);
        start_pulse();
        check("c_busy", 64'(busy), 64'(1));
        check("c_commits_mid", 64'(evq.size()), 64'(2));
        feed(NB * BPW - 2 * BPW - 5, 0);
        wait_done();
        check_seq("c", 1);

        // Asynchronous abort after 8 bits of block 1.
        fill_rand();
        evq.delete();
        bitq.delete();
        load_words();
        start_pulse();
        feed(BPW + 8, 0);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("abort");
        repeat (3) @(posedge clk);
        #1;
        check("abort_commits", 64'(evq.size()), 64'(1));
        if (evq.size() > 0) begin
            check("abort_strobe0", 64'(evq[0].cs), 64'(1));
            check("abort_word0", 64'(evq[0].w), 64'(words[0]));
        end
        check_quiet("abort_hold");
        rst = 1'b0;
        bitq.delete();

`ifdef CONFIG_PARITY_EN
        // Good parity commits, bad parity traps in ERROR until a new start.
        evq.delete();
        push_word(16'h0001, 1'b0);
        push_word(16'h0003, 1'b1);
        start_pulse();
        feed(2 * BPW, 0);
        check("par_err", 64'(err), 64'(1));
        check("par_busy", 64'(busy), 64'(0));
        check("par_ready", 64'(cfg_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("par_err_held", 64'(err), 64'(1));
        check("par_commits", 64'(evq.size()), 64'(1));
        if (evq.size() > 0) begin
            check("par_strobe0", 64'(evq[0].cs), 64'(1));
            check("par_word0", 64'(evq[0].w), 64'(16'h0001));
        end
        fill_rand();
        evq.delete();
        bitq.delete();
        load_words();
        start_pulse();
        check("par_err_clr", 64'(err), 64'(0));
        feed(NB * BPW, 0);
        wait_done();
        check_seq("par", 0);
`endif

        check("invariants", 64'(inv_err), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 16, meaning the number of config bits per latch block.
REQ-002 SHALL have parameter NUM_BLOCKS, default 4, meaning the number of latch blocks sequenced (2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a load sequence.
REQ-006 SHALL have port cfg_valid, input, 1, which qualifies cfg_bit.
REQ-007 SHALL have port cfg_bit, input, 1, the serial config data.
REQ-008 SHALL have port cfg_ready, output, 1; a bit is accepted on a cycle where cfg_valid and cfg_ready are both high.
REQ-009 SHALL have port config_out, output, MEM_SIZE, the parallel word driven to every block's config_in.
REQ-010 SHALL have port comb_set, output, NUM_BLOCKS, a one-hot per-block write strobe.
REQ-011 SHALL have port busy, output, 1, high in SHIFT or COMMIT.
REQ-012 SHALL have port done, output, 1, high in DONE.
REQ-013 SHALL have port err, output, 1, high in ERROR; exists only with CONFIG_PARITY_EN.

Function
REQ-014 SHALL implement states IDLE, SHIFT, COMMIT, DONE, and ERROR (ERROR only with CONFIG_PARITY_EN).
REQ-015 In IDLE, DONE or ERROR, start SHALL move to SHIFT next cycle, clearing block index, bit count, done and err.
REQ-016 start SHALL be ignored in SHIFT and COMMIT.
REQ-017 cfg_ready SHALL be high only in SHIFT, decoded from state registers only.
REQ-018 Each accepted bit SHALL shift right into the word register (new bit enters MSB), so the first accepted bit lands in config_out[0] after MEM_SIZE accepts.
REQ-019 Cycles with cfg_valid low SHALL leave the shift register and counters unchanged; there is no timeout.
REQ-020 The transfer after the last required bit is accepted SHALL be SHIFT -> COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle, with comb_set[index]=1, all other comb_set bits 0, and config_out stable.
REQ-022 comb_set SHALL be decoded from registered state and index only, so it is glitch-free and is 0 in every state other than COMMIT.
REQ-023 On leaving COMMIT, the index SHALL increment; index == NUM_BLOCKS-1 goes to DONE, otherwise back to SHIFT.
REQ-024 Blocks SHALL be written in order 0..NUM_BLOCKS-1, each exactly once per sequence.
REQ-025 config_out SHALL hold the last committed word in DONE and IDLE.
REQ-026 The bit counter SHALL be $clog2(MEM_SIZE+1) bits wide and SHALL wrap to 0 on entry to COMMIT.

Reset
REQ-027 While rst is high, the block SHALL asynchronously force: state IDLE, index 0, counter 0, config_out 0, comb_set 0, cfg_ready 0, busy 0, done 0, err 0.
REQ-028 rst asserted mid-sequence SHALL abort it with no comb_set pulse, and previously written blocks SHALL be left untouched.
REQ-029 The first start is honoured on the first clk edge after rst deasserts.

Configuration
REQ-030 With CONFIG_PARITY_EN defined, each word SHALL be followed by one even-parity bit, so MEM_SIZE+1 accepts occur per block.
REQ-031 With CONFIG_PARITY_EN defined, the parity bit SHALL not enter config_out.
REQ-032 With CONFIG_PARITY_EN defined, a parity mismatch SHALL go SHIFT -> ERROR with no comb_set, and err SHALL be held until start or rst.
REQ-033 Without CONFIG_PARITY_EN, exactly MEM_SIZE accepts occur per block, there is no ERROR state, and err is absent.

Verification
REQ-034 Defaults, no parity: start, then stream 64 bits with cfg_valid held high -> comb_set = 0001, 0010, 0100, 1000, each exactly one cycle apart by 17 cycles; first word's bits 0xA5C3 LSB-first give config_out=0xA5C3 during comb_set=0001; done=1 afterward.
REQ-035 Gapped cfg_valid (high every third cycle) -> identical words and strobe order, with cfg_ready high throughout SHIFT.
REQ-036 start pulsed during SHIFT of block 2 -> ignored; the sequence completes normally.
REQ-037 rst asserted after 8 bits of block 1 -> all outputs 0 immediately; block 0 was written once; comb_set[1] never pulses.
REQ-038 With CONFIG_PARITY_EN: word 0x0001 plus parity bit 1 -> committed; word 0x0003 plus parity bit 1 -> err=1, no comb_set, state ERROR; a new start -> err=0 and reload from block 0.
REQ-039 start in DONE -> new sequence begins, with done falling on the next cycle.
